uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter BAUDRATE, default 9600: serial bit rate in bits/s.
REQ-002 The block SHALL have parameter CLKFREQUENCY, default 100_000_000: clk frequency in Hz.
REQ-003 The block SHALL have parameter PACKAGESIZE, default 8: data bits per frame, range 5-9.
REQ-004 The block SHALL have parameter PARITYEXISTENCE, default "NO": one of "NO", "ODD" or "EVEN".
REQ-005 The block SHALL have parameter SHIFT, default "MSBFIRST": "MSBFIRST" or "LSBFIRST" data bit order on the line.
REQ-006 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is clocked on the rising edge.
REQ-007 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have the port fifoData, input, PACKAGESIZE bits: word from the upstream FIFO, valid the cycle after fifoRead.
REQ-009 The block SHALL have the port fifoEmpty, input, 1 bit: the upstream FIFO holds no word.
REQ-010 The block SHALL have the port fifoRead, output, 1 bit: one-cycle pop strobe to the FIFO.
REQ-011 The block SHALL have the port tx, output, 1 bit: serial line, idle high, registered.
REQ-012 The block SHALL have the port busy, output, 1 bit: high from the fifoRead cycle through the last stop-bit cycle.

Function
REQ-013 Bit period SHALL be BAUDRATECYCLE = CLKFREQUENCY/BAUDRATE clk cycles, integer-truncated; every bit (start, data, parity, stop) SHALL hold tx for exactly BAUDRATECYCLE cycles.
REQ-014 The FSM SHALL have the states IDLE, LOAD, START, DATA, PARITY and STOP, and no others; an illegal state SHALL go to IDLE on the next cycle.
REQ-015 In IDLE, when fifoEmpty=0, the block SHALL assert fifoRead for exactly one cycle and go to LOAD; otherwise it SHALL stay in IDLE with tx=1.
REQ-016 In LOAD, the block SHALL capture fifoData into a shift register, compute the parity bit and go to START; it SHALL ignore fifoData after capture.
REQ-017 START SHALL drive tx=0 for one bit period, beginning on the cycle after LOAD, then go to DATA.
REQ-018 DATA SHALL send PACKAGESIZE bits: fifoData[PACKAGESIZE-1] first for "MSBFIRST", fifoData[0] first for "LSBFIRST".
REQ-019 After the last data bit, the FSM SHALL go to PARITY, or to STOP when PARITYEXISTENCE="NO".
REQ-020 The parity bit SHALL be ~^data for "ODD" and ^data for "EVEN", so that the count of ones over data plus parity is odd or even respectively.
REQ-021 STOP SHALL drive tx=1 for the configured stop length and then return to IDLE.
REQ-022 Back-to-back frames SHALL have exactly 2 extra cycles of tx=1 after the stop bit (the IDLE and LOAD cycles).
REQ-023 fifoEmpty SHALL be ignored in every state except IDLE; fifoRead SHALL never assert outside IDLE.
REQ-024 Bit and cycle counters SHALL be sized from $clog2 of their maxima and SHALL not wrap within a frame.

Reset
REQ-025 On rst=1, at the next clk edge, the block SHALL set state=IDLE, tx=1, busy=0, fifoRead=0, clear all counters and clear the shift register.
REQ-026 Reset mid-frame SHALL abort the frame: tx SHALL be 1 on the next cycle, the captured word SHALL be discarded, and no fifoRead SHALL assert while rst=1.

Configuration
REQ-027 With macro UART_TX_TWO_STOP_BITS_EN defined, STOP SHALL last 2*BAUDRATECYCLE cycles; without it, STOP SHALL last BAUDRATECYCLE cycles.

Verification
REQ-028 Bench SHALL cover: CLKFREQUENCY=16, BAUDRATE=1, PACKAGESIZE=8, "NO", "LSBFIRST", push 0xA5 -> fifoRead at cycle N, tx=0 over cycles N+2..N+17, data bits 1,0,1,0,0,1,0,1 at 16 cycles each, stop high 16 cycles, then busy=0.
REQ-029 Bench SHALL cover: same setup with "MSBFIRST" and "EVEN", push 0x03 -> data bits 0,0,0,0,0,0,1,1, then parity bit 0.
REQ-030 Bench SHALL cover: "ODD", push 0x00 -> parity bit 1; push 0x01 -> parity bit 0.
REQ-031 Bench SHALL cover: FIFO preloaded with 3 words -> 3 frames, each start bit exactly 2 cycles after the previous stop bit ends, and exactly 3 fifoRead pulses.
REQ-032 Bench SHALL cover: rst pulsed at the 4th data bit -> tx=1 the next cycle, no further bits sent; a new word after reset is sent as a clean frame.
REQ-033 Bench SHALL cover: UART_TX_TWO_STOP_BITS_EN defined -> stop high for 32 cycles before the next fifoRead is possible.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter that pops words from an upstream FIFO and
// sends each one as a frame: start bit, PACKAGESIZE data bits, optional
// parity bit, then the stop bit(s).
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   fifoData  - word from the FIFO, valid the cycle after fifoRead
//   fifoEmpty - FIFO holds no word; only looked at while idle
//   fifoRead  - one-cycle pop strobe (decoded from the idle state)
//   tx        - serial line, idle high, registered
//   busy      - high from the fifoRead cycle through the last stop cycle
//
// Build option: define UART_TX_TWO_STOP_BITS_EN to send two stop bits
// instead of one.
module uart_tx #(
    parameter int unsigned BAUDRATE        = 9600,
    parameter int unsigned CLKFREQUENCY    = 100_000_000,
    parameter int unsigned PACKAGESIZE     = 8,
    parameter string       PARITYEXISTENCE = "NO",
    parameter string       SHIFT           = "MSBFIRST"
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PACKAGESIZE-1:0] fifoData,
    input  logic                   fifoEmpty,
    output logic                   fifoRead,
    output logic                   tx,
    output logic                   busy
);

    localparam int unsigned BAUDRATECYCLE = CLKFREQUENCY / BAUDRATE;
`ifdef UART_TX_TWO_STOP_BITS_EN
    localparam int unsigned STOP_BITS = 2;
`else
    localparam int unsigned STOP_BITS = 1;
`endif
    localparam int unsigned STOP_CYCLES = BAUDRATECYCLE * STOP_BITS;
    localparam int unsigned CNT_W       = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;
    localparam int unsigned BIT_W       = $clog2(PACKAGESIZE);
    localparam bit          MSB_FIRST   = (SHIFT == "MSBFIRST");
    localparam bit          PARITY_EN   = (PARITYEXISTENCE != "NO");
    localparam bit          PARITY_ODD  = (PARITYEXISTENCE == "ODD");

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [PACKAGESIZE-1:0] shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   last_bit_cyc;
    logic                   last_stop_cyc;

    assign last_bit_cyc  = (cnt_q == CNT_W'(BAUDRATECYCLE - 1));
    assign last_stop_cyc = (cnt_q == CNT_W'(STOP_CYCLES - 1));
    assign tx            = tx_q;

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // Next state, counters and outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        fifoRead = 1'b0;
        tx_d     = 1'b1;
        busy     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!fifoEmpty) begin
                    fifoRead = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                shreg_d = fifoData;
                par_d   = PARITY_ODD ? ~^fifoData : ^fifoData;
                cnt_d   = '0;
                state_d = START;
            end
            START: begin
                if (last_bit_cyc) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (last_bit_cyc) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(PACKAGESIZE - 1)) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        // Line bit always sits at the exit end of the register
                        shreg_d = MSB_FIRST ? {shreg_q[PACKAGESIZE-2:0], 1'b0}
                                            : {1'b0, shreg_q[PACKAGESIZE-1:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (last_bit_cyc) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (last_stop_cyc) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        // No pop may be issued while reset is held
        if (rst) begin
            fifoRead = 1'b0;
        end

        // tx is registered, so it is computed from the state being entered
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = MSB_FIRST ? shreg_d[PACKAGESIZE-1] : shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase

        busy = fifoRead | (state_q != IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx. Three instances (LSB-first/no parity,
// MSB-first/even, MSB-first/odd) share one clock; one is exercised at a time
// against a frame-level model that expands each popped word into the
// expected per-cycle tx/busy/fifoRead sequence.
module tb_uart_tx;

    localparam int unsigned BRC = 16;
`ifdef UART_TX_TWO_STOP_BITS_EN
    localparam int unsigned STOP_N = 2;
`else
    localparam int unsigned STOP_N = 1;
`endif

    typedef struct packed {
        logic tx;
        logic busy;
        logic rd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_w   [3];
    logic       empty_w [3];
    logic [7:0] data_w  [3];
    logic       rd_w    [3];
    logic       tx_w    [3];
    logic       busy_w  [3];

    uart_tx #(.BAUDRATE(1), .CLKFREQUENCY(16), .PACKAGESIZE(8),
              .PARITYEXISTENCE("NO"), .SHIFT("LSBFIRST")) dut_lsb_none (
        .clk(clk), .rst(rst_w[0]), .fifoData(data_w[0]), .fifoEmpty(empty_w[0]),
        .fifoRead(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

    uart_tx #(.BAUDRATE(1), .CLKFREQUENCY(16), .PACKAGESIZE(8),
              .PARITYEXISTENCE("EVEN"), .SHIFT("MSBFIRST")) dut_msb_even (
        .clk(clk), .rst(rst_w[1]), .fifoData(data_w[1]), .fifoEmpty(empty_w[1]),
        .fifoRead(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

    uart_tx #(.BAUDRATE(1), .CLKFREQUENCY(16), .PACKAGESIZE(8),
              .PARITYEXISTENCE("ODD"), .SHIFT("MSBFIRST")) dut_msb_odd (
        .clk(clk), .rst(rst_w[2]), .fifoData(data_w[2]), .fifoEmpty(empty_w[2]),
        .fifoRead(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         rd_count = 0;
    int         cur      = 0;
    logic       rst_req  = 1'b1;
    logic       rd_prev  = 1'b0;
    logic [7:0] fq[$];
    exp_t       expq[$];

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut=%0d cyc=%0d observed=%b expected=%b", tag, cur, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut=%0d cyc=%0d observed=%0d expected=%0d", tag, cur, cyc, obs, exp);
        end
    endtask

    // Parity that makes the total count of ones even (dut 1) or odd (dut 2)
    function automatic logic parity_bit(input logic [7:0] w);
        int ones;
        ones = $countones(w);
        if (cur == 1) return ((ones % 2) == 1);
        return ((ones % 2) == 0);
    endfunction

    function automatic void push_bit(input logic b);
        exp_t e;
        e.tx = b; e.busy = 1'b1; e.rd = 1'b0;
        for (int i = 0; i < int'(BRC); i++) expq.push_back(e);
    endfunction

    // Whole frame from the pop cycle: pop, load, start, data, parity, stop
    function automatic void build_frame(input logic [7:0] w);
        exp_t e;
        e.tx = 1'b1; e.busy = 1'b1; e.rd = 1'b1;
        expq.push_back(e);
        e.rd = 1'b0;
        expq.push_back(e);
        push_bit(1'b0);
        for (int i = 0; i < 8; i++) push_bit((cur == 0) ? w[i] : w[7-i]);
        if (cur != 0) push_bit(parity_bit(w));
        for (int s = 0; s < int'(STOP_N); s++) push_bit(1'b1);
    endfunction

    // One clock: drive after the rising edge, check on the falling edge
    task automatic cycle(input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        rst_w[cur] = rst_req;
        if (rd_prev && fq.size() > 0) data_w[cur] = fq.pop_front();
        else                          data_w[cur] = 8'($urandom);
        empty_w[cur] = (fq.size() == 0);
        if (expq.size() == 0) begin
            if (!empty_w[cur] && !rst_req) begin
                build_frame(fq[0]);
            end else begin
                e.tx = 1'b1; e.busy = 1'b0; e.rd = 1'b0;
                expq.push_back(e);
            end
        end
        e = expq.pop_front();
        if (rst_req) begin
            e.rd = 1'b0;
            expq.delete();
        end
        @(negedge clk);
        if (chk) begin
            check_bit("tx", tx_w[cur], e.tx);
            check_bit("busy", busy_w[cur], e.busy);
            check_bit("fifoRead", rd_w[cur], e.rd);
        end
        rd_prev = (rd_w[cur] === 1'b1);
        if (rd_prev) rd_count++;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((expq.size() != 0 || fq.size() != 0) && k < 3000) begin
            cycle(1'b1);
            k++;
        end
        check_int("drain_left", expq.size() + fq.size(), 0);
        repeat (3) cycle(1'b1);
    endtask

    // Select a DUT and hold it in reset for two cycles with the FIFO non-empty
    task automatic start_phase(input int p, input logic [7:0] first);
        cur     = p;
        rd_prev = 1'b0;
        expq.delete();
        fq.push_back(first);
        rst_req = 1'b1;
        cycle(1'b1);
        cycle(1'b1);
        rst_req = 1'b0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < 3; i++) begin
            rst_w[i]   = 1'b1;
            empty_w[i] = 1'b1;
            data_w[i]  = 8'h00;
        end
        repeat (2) cycle(1'b0);

        // LSB first, no parity: 0xA5 then three back-to-back words
        start_phase(0, 8'hA5);
        drain();
        rd_count = 0;
        repeat (3) fq.push_back(8'($urandom));
        drain();
        check_int("rd_pulses", rd_count, 3);

        // Reset inside the 4th data bit, then a fresh word
        fq.push_back(8'($urandom));
        k = 0;
        while (!rd_prev && k < 100) begin
            cycle(1'b1);
            k++;
        end
        check_bit("rd_seen", rd_prev, 1'b1);
        repeat (1 + 16 + 48 + 5) cycle(1'b1);
        fq.push_back(8'h3C);
        rst_req = 1'b1;
        cycle(1'b1);
        cycle(1'b1);
        rst_req = 1'b0;
        drain();

        // MSB first, even parity
        start_phase(1, 8'h03);
        drain();
        repeat (2) fq.push_back(8'($urandom));
        drain();

        // MSB first, odd parity
        start_phase(2, 8'h00);
        fq.push_back(8'h01);
        fq.push_back(8'($urandom));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
